// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and gray/binary pointer conversions
// used by both the write-side and read-side pointer logic.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE     = 4;
  localparam int FIFO_DSIZE        = 8;
  localparam int FIFO_AFULL_THRESH = 12;

  typedef logic [FIFO_ADDRSIZE:0] fifo_ptr_t;

  function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic fifo_ptr_t gray2bin_f(input fifo_ptr_t g);
    fifo_ptr_t b;
    b[FIFO_ADDRSIZE] = g[FIFO_ADDRSIZE];
    for (int i = FIFO_ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter of arbitrary width; each binary bit is
// the XOR of all gray bits at or above its position.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int W = FIFO_ADDRSIZE + 1
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/wfifo_stream_writer.sv
// Write-domain front end of the async FIFO: valid/ready stream into a main+skid register
// pair driving winc/wdata. Define WFIFO_LEVEL_EN to build the wlevel/wafull occupancy logic.
module wfifo_stream_writer
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int DSIZE        = FIFO_DSIZE,
  parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  input  logic [DSIZE-1:0]    s_data,
  output logic                s_ready,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wafull
);

  logic             r_mv;
  logic [DSIZE-1:0] r_mdata;
  logic             r_sv;
  logic [DSIZE-1:0] r_sdata;
  logic             r_s_ready;

  logic             w_acc;
  logic             w_push;
  logic             w_mv_next;
  logic [DSIZE-1:0] w_mdata_next;
  logic             w_sv_next;
  logic [DSIZE-1:0] w_sdata_next;

  assign w_acc  = r_mv & ~wfull;
  assign w_push = s_valid & r_s_ready;

  // S only ever fills while M is stalled, so draining S into M keeps order intact.
  always_comb begin
    w_mv_next    = r_mv;
    w_mdata_next = r_mdata;
    w_sv_next    = r_sv;
    w_sdata_next = r_sdata;
    if (!r_mv || w_acc) begin
      if (r_sv) begin
        w_mv_next    = 1'b1;
        w_mdata_next = r_sdata;
        w_sv_next    = 1'b0;
      end else if (w_push) begin
        w_mv_next    = 1'b1;
        w_mdata_next = s_data;
      end else begin
        w_mv_next    = 1'b0;
      end
    end else if (w_push) begin
      w_sv_next    = 1'b1;
      w_sdata_next = s_data;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_mv      <= 1'b0;
      r_mdata   <= '0;
      r_sv      <= 1'b0;
      r_sdata   <= '0;
      r_s_ready <= 1'b0;
    end else begin
      r_mv      <= w_mv_next;
      r_mdata   <= w_mdata_next;
      r_sv      <= w_sv_next;
      r_sdata   <= w_sdata_next;
      r_s_ready <= ~w_sv_next;
    end
  end

  assign winc    = r_mv;
  assign wdata   = r_mdata;
  assign s_ready = r_s_ready;

`ifdef WFIFO_LEVEL_EN
  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE + 1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_level_next;
  logic [ADDRSIZE:0] r_wlevel;
  logic              r_wafull;

  gray2bin #(.W(ADDRSIZE + 1)) u_wptr_g2b (
    .i_gray (wptr),
    .o_bin  (w_wbin)
  );

  gray2bin #(.W(ADDRSIZE + 1)) u_rptr_g2b (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  // Modulo subtraction covers pointer wrap; an MSB-only difference yields full depth.
  assign w_level_next = w_wbin - w_rbin;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wlevel <= '0;
      r_wafull <= 1'b0;
    end else begin
      r_wlevel <= w_level_next;
      r_wafull <= (w_level_next >= AFULL_LVL);
    end
  end

  assign wlevel = r_wlevel;
  assign wafull = r_wafull;
`else
  logic w_unused_ptrs;
  assign w_unused_ptrs = ^{wptr, wq2_rptr};
  assign wlevel        = '0;
  assign wafull        = 1'b0;
`endif

endmodule

// File: tb/tb_wfifo_stream_writer.sv
// Bench for wfifo_stream_writer: directed scenarios plus a randomized run checked
// against a two-deep ordered-queue model of the stream path and a pointer-difference level model.
module tb_wfifo_stream_writer;

`ifdef WFIFO_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif
  localparam int THRESH = 12;

  logic       wclk;
  logic       wrst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       wfull;
  logic [4:0] wptr;
  logic [4:0] wq2_rptr;
  logic       winc;
  logic [7:0] wdata;
  logic [4:0] wlevel;
  logic       wafull;

  int n_vec = 0;
  int n_bad = 0;

  wfifo_stream_writer #(.ADDRSIZE(4), .DSIZE(8), .AFULL_THRESH(THRESH)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .wfull    (wfull),
    .wptr     (wptr),
    .wq2_rptr (wq2_rptr),
    .winc     (winc),
    .wdata    (wdata),
    .wlevel   (wlevel),
    .wafull   (wafull)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic test_reset();
    wrst_n = 1'b0; s_valid = 1'b1; s_data = 8'hAA; wfull = 1'b0;
    wptr = 5'h00; wq2_rptr = 5'h00;
    step(); step();
    n_vec++; if (winc !== 1'b0) begin n_bad++; $display("FAIL reset_winc: got %0b want 0", winc); end
    n_vec++; if (wdata !== 8'h00) begin n_bad++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %0b want 0", s_ready); end
    n_vec++; if (wlevel !== 5'd0) begin n_bad++; $display("FAIL reset_wlevel: got %0d want 0", wlevel); end
    n_vec++; if (wafull !== 1'b0) begin n_bad++; $display("FAIL reset_wafull: got %0b want 0", wafull); end
    wrst_n = 1'b1; s_valid = 1'b0;
    step();
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL release_s_ready: got %0b want 1", s_ready); end
    n_vec++; if (winc !== 1'b0) begin n_bad++; $display("FAIL release_winc: got %0b want 0", winc); end
    $display("reset: done");
  endtask

  task automatic test_streaming();
    wfull = 1'b0; s_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_data = 8'(i);
      step();
      n_vec++; if (winc !== 1'b1) begin n_bad++; $display("FAIL stream_winc[%0d]: got %0b want 1", i, winc); end
      n_vec++; if (wdata !== 8'(i)) begin n_bad++; $display("FAIL stream_wdata[%0d]: got %0h want %0h", i, wdata, i); end
      n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL stream_s_ready[%0d]: got %0b want 1", i, s_ready); end
      $display("stream: word %0h presented", wdata);
    end
    s_valid = 1'b0;
    step();
    n_vec++; if (winc !== 1'b0) begin n_bad++; $display("FAIL stream_drain_winc: got %0b want 0", winc); end
  endtask

  task automatic test_back_pressure();
    wfull = 1'b0; s_valid = 1'b1; s_data = 8'h05;
    step();
    wfull = 1'b1; s_data = 8'h06;
    step();
    s_valid = 1'b0;
    n_vec++; if (wdata !== 8'h05) begin n_bad++; $display("FAIL bp_hold_wdata: got %0h want 05", wdata); end
    n_vec++; if (winc !== 1'b1) begin n_bad++; $display("FAIL bp_hold_winc: got %0b want 1", winc); end
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready: got %0b want 0", s_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (winc !== 1'b1 || wdata !== 8'h05) begin n_bad++; $display("FAIL bp_stall[%0d]: got winc=%0b wdata=%0h want 1/05", i, winc, wdata); end
    end
    wfull = 1'b0;
    step();
    n_vec++; if (winc !== 1'b1 || wdata !== 8'h06) begin n_bad++; $display("FAIL bp_release_wdata: got winc=%0b wdata=%0h want 1/06", winc, wdata); end
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_s_ready: got %0b want 1", s_ready); end
    step();
    n_vec++; if (winc !== 1'b0) begin n_bad++; $display("FAIL bp_drain_winc: got %0b want 0", winc); end
    $display("back_pressure: done");
  endtask

  task automatic test_level();
    logic [4:0] e_lvl;
    logic       e_af;
    s_valid = 1'b0; wfull = 1'b0;
    wptr = 5'h0A; wq2_rptr = 5'h00;
    step();
    e_lvl = LVL_EN ? 5'd12 : 5'd0; e_af = LVL_EN;
    n_vec++; if (wlevel !== e_lvl) begin n_bad++; $display("FAIL level12: got %0d want %0d", wlevel, e_lvl); end
    n_vec++; if (wafull !== e_af) begin n_bad++; $display("FAIL afull12: got %0b want %0b", wafull, e_af); end
    wq2_rptr = 5'h01;
    #1;
    n_vec++; if (wlevel !== e_lvl) begin n_bad++; $display("FAIL level_latency: got %0d want %0d", wlevel, e_lvl); end
    step();
    e_lvl = LVL_EN ? 5'd11 : 5'd0;
    n_vec++; if (wlevel !== e_lvl) begin n_bad++; $display("FAIL level11: got %0d want %0d", wlevel, e_lvl); end
    n_vec++; if (wafull !== 1'b0) begin n_bad++; $display("FAIL afull11: got %0b want 0", wafull); end
    $display("level: done");
  endtask

  task automatic test_wrap();
    logic [4:0] e_lvl;
    wptr = 5'h1A; wq2_rptr = 5'h07;
    step();
    e_lvl = LVL_EN ? 5'd14 : 5'd0;
    n_vec++; if (wlevel !== e_lvl) begin n_bad++; $display("FAIL wrap14: got %0d want %0d", wlevel, e_lvl); end
    n_vec++; if (wafull !== LVL_EN) begin n_bad++; $display("FAIL wrap14_afull: got %0b want %0b", wafull, LVL_EN); end
    wptr = 5'h18; wq2_rptr = 5'h00;
    step();
    e_lvl = LVL_EN ? 5'd16 : 5'd0;
    n_vec++; if (wlevel !== e_lvl) begin n_bad++; $display("FAIL wrap16: got %0d want %0d", wlevel, e_lvl); end
    n_vec++; if (wafull !== LVL_EN) begin n_bad++; $display("FAIL wrap16_afull: got %0b want %0b", wafull, LVL_EN); end
    $display("wrap: done");
  endtask

  task automatic test_reset_mid();
    wfull = 1'b0; s_valid = 1'b1; s_data = 8'h11;
    step();
    wfull = 1'b1; s_data = 8'h22;
    step();
    s_valid = 1'b0;
    n_vec++; if (s_ready !== 1'b0 || wdata !== 8'h11) begin n_bad++; $display("FAIL rstmid_setup: got s_ready=%0b wdata=%0h want 0/11", s_ready, wdata); end
    wrst_n = 1'b0;
    step();
    n_vec++; if (winc !== 1'b0) begin n_bad++; $display("FAIL rstmid_winc: got %0b want 0", winc); end
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_s_ready: got %0b want 0", s_ready); end
    wrst_n = 1'b1; wfull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++; if (winc !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale[%0d]: got winc=%0b wdata=%0h want 0", i, winc, wdata); end
    end
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %0b want 1", s_ready); end
    s_valid = 1'b1; s_data = 8'h33;
    step();
    s_valid = 1'b0;
    n_vec++; if (winc !== 1'b1 || wdata !== 8'h33) begin n_bad++; $display("FAIL rstmid_fresh: got winc=%0b wdata=%0h want 1/33", winc, wdata); end
    step();
    $display("reset_mid: done");
  endtask

  // Model: the stream path behaves as an ordered queue holding at most two words.
  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [4:0] e_lvl;
    logic       e_af;
    bit         rst;
    int         wb, rb;
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      wrst_n  = !rst;
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = 8'($urandom);
      wfull   = ($urandom_range(0, 3) == 0);
      wb      = $urandom_range(0, 31);
      rb      = (wb - $urandom_range(0, 16)) & 31;
      wptr    = to_gray(wb);
      wq2_rptr = to_gray(rb);
      if (rst) begin
        q.delete();
      end else begin
        if (winc && !wfull && q.size() > 0) begin
          exp_d = q.pop_front();
          n_vec++; if (wdata !== exp_d) begin n_bad++; $display("FAIL rand_write[%0d]: got %0h want %0h", c, wdata, exp_d); end
          $display("random[%0d]: wrote %0h", c, wdata);
        end
        if (s_valid && s_ready) q.push_back(s_data);
      end
      step();
      e_lvl = (rst || !LVL_EN) ? 5'd0 : 5'((wb - rb) & 31);
      e_af  = (e_lvl >= 5'(THRESH));
      n_vec++; if (winc !== (q.size() != 0)) begin n_bad++; $display("FAIL rand_winc[%0d]: got %0b want %0b", c, winc, q.size() != 0); end
      if (q.size() != 0) begin
        n_vec++; if (wdata !== q[0]) begin n_bad++; $display("FAIL rand_wdata[%0d]: got %0h want %0h", c, wdata, q[0]); end
      end
      n_vec++; if (s_ready !== (!rst && q.size() < 2)) begin n_bad++; $display("FAIL rand_s_ready[%0d]: got %0b want %0b", c, s_ready, !rst && q.size() < 2); end
      n_vec++; if (wlevel !== e_lvl) begin n_bad++; $display("FAIL rand_wlevel[%0d]: got %0d want %0d", c, wlevel, e_lvl); end
      n_vec++; if (wafull !== e_af) begin n_bad++; $display("FAIL rand_wafull[%0d]: got %0b want %0b", c, wafull, e_af); end
    end
    wrst_n = 1'b1; s_valid = 1'b0; wfull = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_level();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
